// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, colour type and the test-pattern palette.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

   typedef logic [11:0] rgb444_t;

   // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic rgb444_t bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_color = 12'hFFF;
         3'd1:    bar_color = 12'hFF0;
         3'd2:    bar_color = 12'h0FF;
         3'd3:    bar_color = 12'h0F0;
         3'd4:    bar_color = 12'hF0F;
         3'd5:    bar_color = 12'hF00;
         3'd6:    bar_color = 12'h00F;
         default: bar_color = 12'h000;
      endcase
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-enabled horizontal/vertical counters with wrap, plus active/sync/frame-end flags.
module vga_sync_counter #(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       en,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       active,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       frame_end
);

   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   // Wrap on equality with the last count, never on natural overflow.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hcount <= '0;
         vcount <= '0;
      end else if (en) begin
         if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
         end else begin
            hcount <= hcount + 10'd1;
         end
      end
   end

   assign active    = (hcount < H_VIS) && (vcount < V_VIS);
   assign hsync_n   = !((hcount >= H_SS) && (hcount < H_SE));
   assign vsync_n   = !((vcount >= V_SS) && (vcount < V_SE));
   assign frame_end = (hcount == H_LAST) && (vcount == V_LAST);

endmodule

// File: rtl/vga_interface.sv
// VGA timing generator with one-tick registered colour/sync and a frame-start REFRESH pulse.
// Define VGA_TEST_PATTERN_EN to replace COLOR_IN with eight vertical colour bars.
module vga_interface #(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        DOWNCOUNTER,
   input  logic [11:0] COLOR_IN,
   output logic [11:0] COLOR_OUT,
   output logic        HS,
   output logic        VS,
   output logic        REFRESH,
   output logic [9:0]  ADDRH,
   output logic [8:0]  ADDRV
);

   import vga_pkg::*;

   localparam logic [9:0] V_VIS = 10'(V_VISIBLE);

   logic [9:0] hcount, vcount;
   logic       active, hsync_n, vsync_n, frame_end;
   rgb444_t    pix;

   vga_sync_counter #(
      .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
   ) u_sync (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .en        (DOWNCOUNTER),
      .hcount    (hcount),
      .vcount    (vcount),
      .active    (active),
      .hsync_n   (hsync_n),
      .vsync_n   (vsync_n),
      .frame_end (frame_end)
   );

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);
   logic [9:0] bar_idx;
   wire        unused_color = ^COLOR_IN;
   assign bar_idx = hcount / BAR_W;
   assign pix     = bar_color(bar_idx[2:0]);
`else
   assign pix = COLOR_IN;
`endif

   assign ADDRH = hcount;
   assign ADDRV = (vcount < V_VIS) ? vcount[8:0] : '0;

   // Colour and sync share one register stage so they stay aligned at the DAC.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         COLOR_OUT <= '0;
         HS        <= 1'b1;
         VS        <= 1'b1;
         REFRESH   <= 1'b0;
      end else begin
         REFRESH <= DOWNCOUNTER && frame_end;
         if (DOWNCOUNTER) begin
            COLOR_OUT <= active ? pix : '0;
            HS        <= hsync_n;
            VS        <= vsync_n;
         end
      end
   end

endmodule

// File: tb/tb_vga_interface.sv
// Scoreboard bench for vga_interface on a reduced raster (80x13 total) so full frames stay short.
module tb_vga_interface;

   localparam int HV = 64, HF = 4, HSW = 8, HB = 4;
   localparam int VV = 6,  VF = 2, VSW = 2, VB = 3;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;

   typedef struct packed {
      logic [11:0] color;
      logic        hs;
      logic        vs;
      logic        refresh;
      logic [9:0]  addrh;
      logic [8:0]  addrv;
   } exp_t;

   localparam exp_t RST_VAL = '{color: 12'h000, hs: 1'b1, vs: 1'b1, refresh: 1'b0,
                                addrh: 10'd0, addrv: 9'd0};

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        DOWNCOUNTER = 1'b0;
   logic [11:0] COLOR_IN = 12'h000;
   logic [11:0] COLOR_OUT;
   logic        HS, VS, REFRESH;
   logic [9:0]  ADDRH;
   logic [8:0]  ADDRV;

   int   passed = 0;
   int   total  = 0;
   int   mh = 0, mv = 0;
   exp_t last = RST_VAL;
   exp_t sb[$];
   exp_t e, got;

   vga_interface #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .DOWNCOUNTER(DOWNCOUNTER), .COLOR_IN(COLOR_IN),
      .COLOR_OUT(COLOR_OUT), .HS(HS), .VS(VS), .REFRESH(REFRESH),
      .ADDRH(ADDRH), .ADDRV(ADDRV)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t sample();
      exp_t s;
      s = '{color: COLOR_OUT, hs: HS, vs: VS, refresh: REFRESH, addrh: ADDRH, addrv: ADDRV};
      return s;
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; last = RST_VAL; sb.delete();
   endtask

   // Drive one CLK, push the expected post-edge outputs, return #1 after the edge.
   task automatic drive(input logic en, input logic [11:0] c);
      exp_t x;
      DOWNCOUNTER = en;
      COLOR_IN    = c;
      x = last;
      x.refresh = 1'b0;
      if (en) begin
         x.color   = (mh < HV && mv < VV) ? c : 12'h000;
         x.hs      = !(mh >= HV + HF && mh < HV + HF + HSW);
         x.vs      = !(mv >= VV + VF && mv < VV + VF + VSW);
         x.refresh = (mh == HT - 1 && mv == VT - 1);
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end
      x.addrh = 10'(mh);
      x.addrv = (mv < VV) ? 9'(mv) : 9'd0;
      last = x;
      sb.push_back(x);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      DOWNCOUNTER = 1'b1;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      got = sample();
      total++;
      if (got !== RST_VAL) $display("FAIL reset_state: got %h want %h", got, RST_VAL);
      else passed++;
      RST_N = 1'b1;
   endtask

   task automatic test_count_toggle();
      for (int i = 0; i < 24; i++) begin
         drive(i % 2 == 0, 12'hABC);
         e = sb.pop_front(); got = sample();
         total++;
         if (got !== e) $display("FAIL toggle_count cyc %0d: got %h want %h", i, got, e);
         else passed++;
      end
   endtask

   task automatic test_hsync_line();
      int   lows = 0;
      logic prev_hs;
      prev_hs = HS;
      for (int i = 0; i < 2 * HT; i++) begin
         drive(1'b1, 12'($urandom_range(0, 4095)));
         e = sb.pop_front(); got = sample();
         total++;
         if (got !== e) $display("FAIL line_pixel tick %0d: got %h want %h", i, got, e);
         else passed++;
         if (i < HT && !HS) lows++;
         if (prev_hs && !HS) begin
            total++;
            if (ADDRH !== 10'(HV + HF + 1)) $display("FAIL hs_fall_pos: got %0d want %0d", ADDRH, HV + HF + 1);
            else passed++;
         end
         prev_hs = HS;
      end
      total++;
      if (lows != HSW) $display("FAIL hs_low_width: got %0d want %0d", lows, HSW);
      else passed++;
   endtask

   task automatic test_frame();
      int vs_low = 0, refr = 0;
      for (int i = 0; i < HT * VT; i++) begin
         drive(1'b1, 12'h5A3);
         e = sb.pop_front(); got = sample();
         total++;
         if (got !== e) $display("FAIL frame_full tick %0d: got %h want %h", i, got, e);
         else passed++;
         if (!VS) vs_low++;
         if (REFRESH) refr++;
      end
      total++;
      if (vs_low != VSW * HT) $display("FAIL vs_low_ticks: got %0d want %0d", vs_low, VSW * HT);
      else passed++;
      total++;
      if (refr != 1) $display("FAIL refresh_per_frame: got %0d want 1", refr);
      else passed++;
      refr = 0;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         drive(i % 2 == 0, 12'h0F7);
         e = sb.pop_front(); got = sample();
         total++;
         if (got !== e) $display("FAIL frame_toggle cyc %0d: got %h want %h", i, got, e);
         else passed++;
         if (REFRESH) refr++;
      end
      total++;
      if (refr != 1) $display("FAIL refresh_one_clk: got %0d want 1", refr);
      else passed++;
   endtask

   task automatic test_freeze();
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, 12'($urandom_range(0, 4095)));
         e = sb.pop_front(); got = sample();
         total++;
         if (got !== e) $display("FAIL freeze cyc %0d: got %h want %h", i, got, e);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int refr = 0;
      for (int i = 0; i < HT * VT && !(mh == 30 && mv == 2); i++) begin
         drive(1'b1, 12'h321);
         void'(sb.pop_front());
      end
      total++;
      if (ADDRH !== 10'd30) $display("FAIL mid_reach: got %0d want 30", ADDRH);
      else passed++;
      #2 RST_N = 1'b0;
      #1 got = sample();
      total++;
      if (got !== RST_VAL) $display("FAIL async_reset: got %h want %h", got, RST_VAL);
      else passed++;
      model_reset();
      @(posedge CLK);
      #1 RST_N = 1'b1;
      for (int i = 0; i < 3 * HT; i++) begin
         drive(1'b1, 12'h9E1);
         e = sb.pop_front(); got = sample();
         total++;
         if (got !== e) $display("FAIL after_reset tick %0d: got %h want %h", i, got, e);
         else passed++;
         if (REFRESH) refr++;
      end
      total++;
      if (refr != 0) $display("FAIL no_refresh_on_release: got %0d want 0", refr);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_count_toggle();
      test_hsync_line();
      test_frame();
      test_freeze();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vga_interface.md
Name: vga_interface

Overview:
- Generates 640x480 @ 60 Hz VGA timing from a system clock gated by a pixel-rate enable.
- Exposes the current pixel coordinate to the upstream image compositor, which returns a 12-bit RGB colour.
- Drives blanked colour, sync and a once-per-frame refresh pulse to the VGA connector.
- Sits between the display compositor and the board's VGA port.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines

Ports:
- CLK  in  1  system clock (50 MHz nominal)
- RST_N  in  1  asynchronous active-low reset
- DOWNCOUNTER  in  1  pixel enable; a CLK edge with DOWNCOUNTER=1 is one pixel tick (25 MHz)
- COLOR_IN  in  12  RGB 4:4:4 colour for the presented coordinate
- COLOR_OUT  out  12  RGB to the DAC; zero while blanked
- HS  out  1  horizontal sync, active low
- VS  out  1  vertical sync, active low
- REFRESH  out  1  one-CLK pulse at frame start
- ADDRH  out  10  current horizontal pixel index
- ADDRV  out  9  current visible line index

Behaviour:
- Reset (RST_N=0, asynchronous):
  - hcount=0, vcount=0.
  - COLOR_OUT=0, HS=1, VS=1, REFRESH=0.
  - ADDRH=0, ADDRV=0.
- All state changes on rising CLK and only when DOWNCOUNTER=1, except REFRESH, which clears on the next CLK edge regardless of enable.
- hcount runs 0..799 (H_TOTAL = sum of H params), wrapping to 0. vcount advances when hcount wraps and runs 0..524 (V_TOTAL).
- ADDRH = hcount (0..799).
- ADDRV = vcount[8:0] while vcount<480; otherwise 0.
- Active region: hcount<640 and vcount<480.
- HS low while 656<=hcount<752. VS low while 490<=vcount<492.
- Output pipeline: on each tick, COLOR_OUT<=COLOR_IN if the previous tick's coordinate was active, else 0. HS and VS are registered with the same one-tick delay so colour and sync stay aligned.
- Upstream must present COLOR_IN for a coordinate before the next pixel tick; one CLK of upstream latency is tolerated.
- REFRESH asserts for exactly one CLK on the tick where hcount=799 and vcount=524 (wrap to 0,0).
- Corner cases:
  - DOWNCOUNTER held low: everything frozen.
  - DOWNCOUNTER held high: runs at CLK rate.
  - Reset mid-frame: restart at (0,0) with no REFRESH pulse.
  - Counter arithmetic is unsigned; the wrap compare is equality, not overflow.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined: COLOR_IN is ignored and the visible area shows 8 vertical colour bars of 80 px each, selected by hcount/80. Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. Blanking and sync are unchanged.
- When undefined: COLOR_IN passes through as described above.

Decomposition:
- Shared package vga_pkg holds:
  - the eight timing constants;
  - derived H_TOTAL=800, V_TOTAL=525, H_SYNC_START=656, V_SYNC_START=490;
  - a typedef for the 12-bit rgb444 colour.
- One sub-module is natural: vga_sync_counter. It holds the enabled h/v counters with wrap, and produces the active, hsync and vsync flags. The top adds the output register stage and REFRESH.

Test Plan:
- Reset then release with DOWNCOUNTER toggling every CLK -> HS, VS high; COLOR_OUT=0; ADDRH counts 0,1,2 on ticks only.
- COLOR_IN=12'hABC constant -> COLOR_OUT=ABC one tick after ADDRH<640 & row<480; 0 from ADDRH=640 delayed one tick.
- Count ticks -> HS low exactly 96 ticks per 800-tick line, falling one tick after ADDRH=656.
- Count lines -> VS low exactly 2 lines per 525-line frame; ADDRV=0 during lines 480..524.
- Run a full frame -> REFRESH high exactly one CLK per 420000 ticks, at wrap to (0,0).
- Assert RST_N low mid-line (ADDRH=300) -> outputs return to reset values asynchronously; no REFRESH on release.
